// File: rtl/mips_cpu_muldiv_if.sv
// EXEC-stage <-> mul/div unit bus: operation request, operands, and HI/LO
// results with busy/done status.
interface mips_cpu_muldiv_if;
  logic        clk_enable;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output clk_enable, start, op, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  clk_enable, start, op, a, b,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mips_cpu_muldiv.sv
// MIPS HI/LO owner: 32-iteration radix-2 shift-add multiply and restoring
// divide on operand magnitudes, with sign fix-up on the final edge.
module mips_cpu_muldiv (
  input  logic                     clk,
  input  logic                     reset,
  mips_cpu_muldiv_if.slave         bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ITER,
    S_FINISH
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;
  logic        r_done;
  logic [5:0]  r_count;
  logic [63:0] r_acc;      // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0] r_opd;      // mul: multiplicand magnitude; div: divisor magnitude
  logic        r_is_div;
  logic        r_signed;
  logic        r_sign_q;
  logic        r_sign_r;
  logic        r_div0;

  logic        w_op_signed;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [32:0] w_div_shift;
  logic        w_div_ge;
  logic [63:0] w_div_next;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  // MULT (0) and DIV (2) are the signed ops; odd codes are unsigned
  assign w_op_signed = ~bus.op[0];
  assign w_mag_a     = (w_op_signed && bus.a[31]) ? -bus.a : bus.a;
  assign w_mag_b     = (w_op_signed && bus.b[31]) ? -bus.b : bus.b;

  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opd} : 33'd0);
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};

  // 33-bit compare keeps a 0x80000000 divisor magnitude exact
  assign w_div_shift = r_acc[63:31];
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opd});
  assign w_div_next  = w_div_ge ? {w_div_shift[31:0] - r_opd, r_acc[30:0], 1'b1}
                                : {w_div_shift[31:0],         r_acc[30:0], 1'b0};

  always_comb begin
    // NOTE: defaults first so every path assigns each output; no latch is inferred.
    w_res_hi = r_acc[63:32];
    w_res_lo = r_acc[31:0];
    if (!r_is_div) begin
      if (r_signed && r_sign_q) {w_res_hi, w_res_lo} = -r_acc;
    end else begin
      if (r_signed && r_sign_q) w_res_lo = -r_acc[31:0];
      if (r_signed && r_sign_r) w_res_hi = -r_acc[63:32];
      // Divide by zero leaves remainder = |a|; the dividend-sign fix restores a itself
      if (r_div0) w_res_lo = 32'hFFFF_FFFF;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start && !bus.op[2]) w_next = S_ITER;
      S_ITER:   if (r_count == 6'd1)         w_next = S_FINISH;
      S_FINISH: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                r_state <= S_IDLE;
    else if (bus.clk_enable)  r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_count  <= 6'd0;
      r_acc    <= 64'd0;
      r_opd    <= 32'd0;
      r_is_div <= 1'b0;
      r_signed <= 1'b0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_div0   <= 1'b0;
    end else if (bus.clk_enable) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values together.
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.op[2]) begin
            r_busy   <= 1'b1;
            r_count  <= 6'd32;
            r_is_div <= bus.op[1];
            r_signed <= w_op_signed;
            r_sign_q <= bus.a[31] ^ bus.b[31];
            r_sign_r <= bus.a[31];
            r_div0   <= (bus.b == 32'd0);
            if (bus.op[1]) begin
              r_acc <= {32'd0, w_mag_a};
              r_opd <= w_mag_b;
            end else begin
              r_acc <= {32'd0, w_mag_b};
              r_opd <= w_mag_a;
            end
          end else if (bus.start && bus.op[1:0] == 2'd0) begin
            r_hi <= bus.a;
          end else if (bus.start && bus.op[1:0] == 2'd1) begin
            r_lo <= bus.a;
          end
        end
        S_ITER: begin
          r_count <= r_count - 6'd1;
          r_acc   <= r_is_div ? w_div_next : w_mul_next;
        end
        S_FINISH: begin
          r_hi   <= w_res_hi;
          r_lo   <= w_res_lo;
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Scoreboarded bench for mips_cpu_muldiv: directed corner cases plus random
// ops checked against an arithmetic reference model.
module tb_mips_cpu_muldiv;

  logic clk;
  logic reset;

  mips_cpu_muldiv_if bus ();

  mips_cpu_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks  = 0;
  int          n_errors  = 0;
  int          n_pushed  = 0;
  int          n_aborted = 0;
  int          n_done    = 0;
  logic [63:0] sb[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  bit          prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference results from plain 64-bit arithmetic; SV division truncates toward zero
  function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb_, q, r;
    logic [63:0] res;
    sa  = $signed(a);
    sb_ = $signed(b);
    res = 64'd0;
    case (op)
      3'd0: begin q = sa * sb_; res = q; end
      3'd1: res = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb_;
          r = sa % sb_;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  // Monitor: one pop per done pulse (done may be held while clk_enable is low)
  always @(negedge clk) begin
    if (reset) begin
      prev_done = 1'b0;
    end else begin
      if (bus.done && !prev_done) begin
        n_done++;
        if (sb.size() == 0) begin
          check("unexpected_done", {bus.hi, bus.lo}, 64'd0);
        end else begin
          logic [63:0] e;
          e = sb.pop_front();
          check("scoreboard_hilo", {bus.hi, bus.lo}, e);
          m_hi = e[63:32];
          m_lo = e[31:0];
        end
      end
      prev_done = bus.done;
    end
  end

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    sb.push_back(exp);
    n_pushed++;
  endtask

  task automatic wait_done(input int exp_cycles, input int already, input string name,
                           input bit settle);
    int n;
    n = already;
    while (bus.busy === 1'b1 && n < 300) begin
      n++;
      if (n == 16) check({name, "_hold"}, {bus.hi, bus.lo}, {m_hi, m_lo});
      @(negedge clk);
    end
    check({name, "_busy_cycles"}, 64'(n), 64'(exp_cycles));
    check({name, "_done_pulse"}, {63'd0, bus.done}, 64'd1);
    if (settle) begin
      @(negedge clk);
      check({name, "_done_clear"}, {63'd0, bus.done}, 64'd0);
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] exp, input string name);
    start_op(op, a, b, exp);
    wait_done(33, 0, name, 1'b1);
  endtask

  task automatic do_mt(input logic [2:0] op, input logic [31:0] a, input string name);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    @(negedge clk);
    bus.start = 1'b0;
    if (op == 3'd4) m_hi = a;
    if (op == 3'd5) m_lo = a;
    check({name, "_hilo"}, {bus.hi, bus.lo}, {m_hi, m_lo});
    check({name, "_busy_done"}, {62'd0, bus.busy, bus.done}, 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b1;
    bus.clk_enable = 1'b1;
    bus.start      = 1'b0;
    bus.op         = 3'd0;
    bus.a          = 32'd0;
    bus.b          = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_state", {bus.hi, bus.lo}, 64'd0);
    check("reset_flags", {62'd0, bus.busy, bus.done}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // MULTU max*max, then done must hold while clk_enable is low
    start_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
    wait_done(33, 0, "multu_max", 1'b0);
    bus.clk_enable = 1'b0;
    repeat (3) @(negedge clk);
    check("done_hold_disabled", {63'd0, bus.done}, 64'd1);
    bus.clk_enable = 1'b1;
    @(negedge clk);
    check("done_clear_enabled", {63'd0, bus.done}, 64'd0);

    run(3'd0, 32'hFFFF_FFFD, 32'd5,          64'hFFFF_FFFF_FFFF_FFF1, "mult_neg");
    run(3'd2, 32'hFFFF_FFF9, 32'd2,          64'hFFFF_FFFF_FFFF_FFFD, "div_neg");
    run(3'd3, 32'd7,         32'd0,          64'h0000_0007_FFFF_FFFF, "divu_zero");
    run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF,  64'h0000_0000_8000_0000, "div_ovf");
    run(3'd2, 32'hFFFF_FFF9, 32'd0,          64'hFFFF_FFF9_FFFF_FFFF, "div_zero_neg");

    do_mt(3'd4, 32'h1234_5678, "mthi");
    do_mt(3'd5, 32'h9ABC_DEF0, "mtlo");
    do_mt(3'd6, 32'hDEAD_BEEF, "op6_noop");
    do_mt(3'd7, 32'hCAFE_F00D, "op7_noop");

    // DIVU with a MULT start while busy and a 10-cycle enable stall
    start_op(3'd3, 32'd100, 32'd7, {32'd2, 32'd14});
    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.a     = $urandom;
    bus.b     = $urandom;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.clk_enable = 1'b0;
    repeat (10) @(negedge clk);
    bus.clk_enable = 1'b1;
    wait_done(43, 11, "divu_stall", 1'b1);

    for (int i = 0; i < 24; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 15));
        default: b = 32'($urandom);
      endcase
      if (op <= 3'd3) run(op, a, b, ref_model(op, a, b), "rand_op");
      else            do_mt(op, a, "rand_mt");
    end

    // Asynchronous reset at iteration 15 of a MULT aborts it
    start_op(3'd0, 32'h7654_3210, 32'hF00D_CAFE, ref_model(3'd0, 32'h7654_3210, 32'hF00D_CAFE));
    repeat (15) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("async_reset_flags", {62'd0, bus.busy, bus.done}, 64'd0);
    sb.delete();
    n_aborted++;
    m_hi = 32'd0;
    m_lo = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run(3'd1, 32'd3, 32'd4, 64'd12, "multu_after_reset");

    repeat (5) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    check("done_count", 64'(n_done), 64'(n_pushed - n_aborted));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
